dcdl_lock_seq: RTL and testbench
================================

Name: dcdl_lock_seq

Overview:
- Lock sequencer for the fractional multiplying DLL's delay line.
- Drives the DCDL control code and the clock-mux Sel mode. Acquires by a successive-approximation (SAR) search, then closes the loop with ±1 tracking, and reports lock and loss-of-lock.
- Sits between the phase detector decision (pd_valid/pd_lead) and the DCDL/clock-mux inputs. Replaces the ad-hoc code stepping in the phase tracking controller.

Parameters:
- CODE_W, 10, DCDL control code width.
- SETTLE_CYC, 4, base settle cycles after any code change; effective settle = SETTLE_CYC*(n_lat+1).
- LOCK_CNT, 8, consecutive direction reversals required to declare lock.
- LOSS_CNT, 4, consecutive same-direction decisions in LOCKED that declare loss of lock.

Ports:
- clk_ext  in  1  reference clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins acquisition from IDLE
- stop  in  1  single-cycle pulse; returns to IDLE from any state
- cfg_n  in  4  multiplication factor N; latched into n_lat on accepted start
- pd_valid  in  1  one-cycle strobe: phase decision available
- pd_lead  in  1  qualified by pd_valid; 1 = output early (increase delay), 0 = late
- code  out  CODE_W  DCDL control code
- sel  out  2  clock-mux mode: 10 gated, 01 reference injected, 00 closed loop
- busy  out  1  high in any state except IDLE
- locked  out  1  high only in LOCKED
- err  out  1  sticky code-saturation flag; cleared on accepted start

Behaviour:
Reset values:
- code=0, sel=2'b10, busy=0, locked=0, err=0
- state=IDLE; all counters 0; n_lat=0

Settle window:
- Every code write loads a settle counter with SETTLE_CYC*(n_lat+1).
- pd_valid is ignored while settle>0.
- A decision is consumed only when pd_valid=1 and settle=0, at most one per cycle.

States:
- IDLE: sel=10, code held.
  - start: latch n_lat, clear err, code=0, go SAR with bit index i=CODE_W-1, code[i]=1 (counts as a code write).
  - start while busy is ignored.
- SAR: sel=01.
  - On a consumed decision: keep code[i] if pd_lead=1, else clear it.
  - If i>0: i--, set code[i]=1 (code write).
  - If i=0: go TRACK, rev_cnt=0, prev_dir cleared (first decision never counts as a reversal).
  - Acquisition takes exactly CODE_W consumed decisions.
- TRACK: sel=00.
  - On a consumed decision: code += 1 if lead, else code -= 1.
  - If dir≠prev_dir (and prev_dir valid): rev_cnt++, else rev_cnt=0. Then prev_dir=dir.
  - Next cycle after rev_cnt reaches LOCK_CNT: go LOCKED, same_cnt=0.
- LOCKED: sel=00, locked=1.
  - Tracking continues as in TRACK.
  - same_cnt++ on same direction as prev_dir, else 0.
  - same_cnt reaching LOSS_CNT: locked=0 on the next cycle, go TRACK, rev_cnt=0.

Saturation:
- Lead at code=all-ones, or lag at code=0: code holds, err=1.
- The decision counts as same-direction (rev_cnt=0, or same_cnt++). No wrap-around ever.

Simultaneous events and reset:
- stop has priority over start and pd_valid in the same cycle.
- stop: IDLE, sel=10, locked=0, code held.
- rst asserted mid-operation returns all outputs to reset values immediately.
- cfg_n changes while busy have no effect until the next start.

Optional Feature:
- Macro: DCDL_LOCK_SEQ_FREEZE_EN.
- Defined: in LOCKED, code is frozen. Decisions only update prev_dir and same_cnt; the first code update happens after the TRACK re-entry on loss.
- Undefined: LOCKED keeps ±1 tracking as specified above.

Decomposition:
- Shared package fmdll_pkg:
  - state enum (IDLE, SAR, TRACK, LOCKED)
  - sel encodings SEL_CLOSED=2'b00, SEL_REF=2'b01, SEL_GATE=2'b10 (also used by the top-level clock mux)
- One sub-module: dcdl_settle_cnt. Loadable down-counter producing settle_done; reused by the phase tracking controller.

Test Plan:
- PD model lead=(code<=421), SETTLE_CYC=4, cfg_n=0 -> after start and 10 consumed decisions: code=421 (0x1A5), sel 01→00, busy=1.
- Continue the same model -> code dithers 421/422; locked=1 after 8 consecutive reversals; err=0.
- Once locked, switch model to lead=(code<=440) -> after 4 same-direction decisions locked=0, state TRACK; relock at code 440/441.
- Model lead=1 always -> SAR yields code=1023; the first TRACK decision sets err=1 and code stays 1023; locked never rises.
- cfg_n=3 -> pd_valid strobes within 16 cycles of any code write are ignored (code unchanged). Also: stop+pd_valid in the same cycle -> IDLE, sel=10, code unchanged.
- rst pulse mid-SAR (after 5 decisions) -> code=0, sel=10, busy=0 asynchronously; a later start re-runs a full 10-step SAR.

Source files
------------

// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared types and constants for the fractional multiplying DLL
//   state_t     : lock sequencer states
//   SEL_*       : clock-mux mode encodings, also used by the top-level clock mux
//   settle_len  : settle window length for a given base and multiplication factor
package fmdll_pkg;

    typedef enum logic [1:0] {IDLE, SAR, TRACK, LOCKED} state_t;

    localparam logic [1:0] SEL_CLOSED = 2'b00;
    localparam logic [1:0] SEL_REF    = 2'b01;
    localparam logic [1:0] SEL_GATE   = 2'b10;

    function automatic int settle_len(input int base, input logic [3:0] n);
        return base * (int'(n) + 1);
    endfunction

endpackage

// File: rtl/dcdl_settle_cnt.sv
// dcdl_settle_cnt: loadable down-counter that flags when a settle window has elapsed
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load val into the counter (takes effect on this edge)
//   val       : settle length in cycles
//   done      : high while the counter is zero
module dcdl_settle_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dcdl_lock_seq.sv
// dcdl_lock_seq: DCDL lock sequencer (SAR acquisition, +/-1 tracking, lock/loss detect)
//   clk_ext, rst      : reference clock, asynchronous active-high reset
//   start, stop       : begin acquisition from IDLE / return to IDLE from anywhere
//   cfg_n             : multiplication factor, latched on accepted start
//   pd_valid, pd_lead : phase decision strobe and direction (1 = increase delay)
//   code, sel         : DCDL control code and clock-mux mode
//   busy, locked, err : not IDLE / in LOCKED / sticky code saturation
//   Build option DCDL_LOCK_SEQ_FREEZE_EN freezes the code while LOCKED.
module dcdl_lock_seq import fmdll_pkg::*; #(
    parameter int CODE_W     = 10,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8,
    parameter int LOSS_CNT   = 4
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [3:0]        cfg_n,
    input  logic              pd_valid,
    input  logic              pd_lead,
    output logic [CODE_W-1:0] code,
    output logic [1:0]        sel,
    output logic              busy,
    output logic              locked,
    output logic              err
);

    localparam int SW = $clog2(SETTLE_CYC * 16 + 1);
    localparam int IW = $clog2(CODE_W);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    state_t            state, nxt;
    logic [CODE_W-1:0] code_n, stepped;
    logic [IW-1:0]     i, i_n;
    logic [3:0]        n_lat, n_n, ld_n;
    logic              err_n, prev_dir, prev_n, prev_vld, pvld_n, wr, sat, take, settle_done;
    logic [RW-1:0]     rev_cnt, rev_n;
    logic [LW-1:0]     same_cnt, same_n;

    dcdl_settle_cnt #(.W(SW)) u_settle (
        .clk  (clk_ext),
        .rst  (rst),
        .load (wr),
        .val  (SW'(settle_len(SETTLE_CYC, ld_n))),
        .done (settle_done)
    );

    always_comb begin
        nxt     = state;
        code_n  = code;
        i_n     = i;
        n_n     = n_lat;
        err_n   = err;
        prev_n  = prev_dir;
        pvld_n  = prev_vld;
        rev_n   = rev_cnt;
        same_n  = same_cnt;
        wr      = 1'b0;
        ld_n    = n_lat;
        sat     = pd_lead ? &code : ~|code;
        stepped = pd_lead ? code + CODE_W'(1) : code - CODE_W'(1);
        take    = pd_valid && settle_done;
        if (stop)
            nxt = IDLE;
        else
            case (state)
                IDLE: if (start) begin
                    nxt    = SAR;
                    n_n    = cfg_n;
                    ld_n   = cfg_n;
                    err_n  = 1'b0;
                    code_n = {1'b1, {(CODE_W-1){1'b0}}};
                    i_n    = IW'(CODE_W - 1);
                    wr     = 1'b1;
                end
                SAR: if (take) begin
                    code_n[i] = pd_lead;
                    wr        = 1'b1;
                    if (i != '0) begin
                        i_n         = i - IW'(1);
                        code_n[i_n] = 1'b1;
                    end else begin
                        nxt    = TRACK;
                        rev_n  = '0;
                        pvld_n = 1'b0;
                    end
                end
                TRACK: if (rev_cnt == RW'(LOCK_CNT)) begin
                    nxt    = LOCKED;
                    same_n = '0;
                end else if (take) begin
                    code_n = sat ? code : stepped;
                    err_n  = err | sat;
                    wr     = !sat;
                    // a saturated decision counts as same-direction
                    rev_n  = (prev_vld && pd_lead != prev_dir && !sat) ? rev_cnt + RW'(1) : '0;
                    prev_n = pd_lead;
                    pvld_n = 1'b1;
                end
                LOCKED: if (same_cnt == LW'(LOSS_CNT)) begin
                    nxt   = TRACK;
                    rev_n = '0;
                end else if (take) begin
`ifdef DCDL_LOCK_SEQ_FREEZE_EN
                    wr     = 1'b0;
`else
                    code_n = sat ? code : stepped;
                    err_n  = err | sat;
                    wr     = !sat;
`endif
                    same_n = (sat || pd_lead == prev_dir) ? same_cnt + LW'(1) : '0;
                    prev_n = pd_lead;
                end
                default: nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            code     <= '0;
            i        <= '0;
            n_lat    <= '0;
            err      <= 1'b0;
            prev_dir <= 1'b0;
            prev_vld <= 1'b0;
            rev_cnt  <= '0;
            same_cnt <= '0;
        end else begin
            state    <= nxt;
            code     <= code_n;
            i        <= i_n;
            n_lat    <= n_n;
            err      <= err_n;
            prev_dir <= prev_n;
            prev_vld <= pvld_n;
            rev_cnt  <= rev_n;
            same_cnt <= same_n;
        end
    end

    assign sel    = (state == IDLE) ? SEL_GATE : (state == SAR) ? SEL_REF : SEL_CLOSED;
    assign busy   = (state != IDLE);
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_dcdl_lock_seq.sv
// tb_dcdl_lock_seq: randomized directed bench for dcdl_lock_seq with a decision-level model
module tb_dcdl_lock_seq;

    localparam int CODE_W = 10, SETTLE = 4, LOCK = 8, LOSS = 4, MAXC = 1023;
`ifdef DCDL_LOCK_SEQ_FREEZE_EN
    localparam bit FREEZE = 1'b1;
`else
    localparam bit FREEZE = 1'b0;
`endif

    logic clk_ext = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, pd_valid = 1'b0, pd_lead = 1'b0;
    logic [3:0] cfg_n = '0;
    logic [CODE_W-1:0] code;
    logic [1:0] sel;
    logic busy, locked, err;

    int checks = 0, errors = 0;
    // model: 0 idle, 1 searching, 2 tracking, 3 locked
    int ms, mcode, mbit, mrev, msame, merr, mprev, mpvld, mn, thr, r;

    always #5 clk_ext = ~clk_ext;

    dcdl_lock_seq #(.CODE_W(CODE_W), .SETTLE_CYC(SETTLE), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
        .clk_ext(clk_ext), .rst(rst), .start(start), .stop(stop), .cfg_n(cfg_n),
        .pd_valid(pd_valid), .pd_lead(pd_lead), .code(code), .sel(sel),
        .busy(busy), .locked(locked), .err(err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("code", int'(code), mcode);
        chk("sel", int'(sel), ms == 0 ? 2 : ms == 1 ? 1 : 0);
        chk("busy", int'(busy), int'(ms != 0));
        chk("locked", int'(locked), int'(ms == 3));
        chk("err", int'(err), merr);
    endtask

    task automatic model_reset();
        ms = 0; mcode = 0; mbit = 0; mrev = 0; msame = 0; merr = 0; mprev = 0; mpvld = 0; mn = 0;
    endtask

    function automatic bit pd(input int t);
        return mcode <= t;
    endfunction

    task automatic apply(input bit lead);
        bit sat;
        if (ms == 1) begin
            if (!lead) mcode &= ~(1 << mbit);
            if (mbit > 0) begin
                mbit--;
                mcode |= 1 << mbit;
            end else begin
                ms = 2; mrev = 0; mpvld = 0;
            end
        end else if (ms >= 2) begin
            sat = lead ? (mcode == MAXC) : (mcode == 0);
            if (!(ms == 3 && FREEZE)) begin
                if (sat) merr = 1;
                else mcode += lead ? 1 : -1;
            end
            if (ms == 2) begin
                mrev = (mpvld != 0 && int'(lead) != mprev && !sat) ? mrev + 1 : 0;
                mprev = int'(lead); mpvld = 1;
                if (mrev == LOCK) begin ms = 3; msame = 0; end
            end else begin
                msame = (sat || int'(lead) == mprev) ? msame + 1 : 0;
                mprev = int'(lead);
                if (msame == LOSS) begin ms = 2; mrev = 0; end
            end
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk_ext);
        cfg_n = 4'(n); start = 1'b1;
        @(negedge clk_ext);
        start = 1'b0;
        cfg_n = 4'($urandom_range(0, 15));
        ms = 1; mn = n; merr = 0; mcode = 1 << (CODE_W - 1); mbit = CODE_W - 1;
        check_all();
    endtask

    task automatic step(input bit lead);
        repeat (SETTLE * (mn + 1) + $urandom_range(0, 3)) @(negedge clk_ext);
        pd_valid = 1'b1; pd_lead = lead;
        @(negedge clk_ext);
        pd_valid = 1'b0; pd_lead = $urandom_range(0, 1);
        apply(lead);
        @(negedge clk_ext);
        check_all();
    endtask

    task automatic spurious(input int wait_cyc);
        repeat (wait_cyc) @(negedge clk_ext);
        pd_valid = 1'b1; pd_lead = $urandom_range(0, 1);
        @(negedge clk_ext);
        pd_valid = 1'b0;
        chk("ignored", int'(code), mcode);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk_ext);
        stop = 1'b0;
        ms = 0;
        check_all();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk_ext);
        rst = 1'b0;

        do_start(0);
        for (int k = 0; k < CODE_W; k++) step(pd(421));
        chk("sar421", int'(code), 421);
        for (int k = 0; k < 30 && ms != 3; k++) step(pd(421));
        chk("lock421", int'(locked), 1);
        chk("dither421", int'(code == 421 || code == 422), 1);
        chk("noerr", int'(err), 0);

        for (int k = 0; k < 10 && ms == 3; k++) step(pd(440));
        chk("loss", int'(locked), 0);
        for (int k = 0; k < 60 && ms != 3; k++) step(pd(440));
        chk("lock440", int'(locked), 1);
        chk("dither440", int'(code == 440 || code == 441), 1);

        repeat (SETTLE + 2) @(negedge clk_ext);
        pd_valid = 1'b1; pd_lead = ~pd(440);
        do_stop();
        pd_valid = 1'b0;

        do_start(0);
        for (int k = 0; k < CODE_W; k++) step(1'b1);
        chk("sarmax", int'(code), MAXC);
        step(1'b1);
        chk("saterr", int'(err), 1);
        chk("satcode", int'(code), MAXC);
        for (int k = 0; k < 12; k++) step(1'b1);
        chk("nolock", int'(locked), 0);
        do_stop();

        do_start(3);
        spurious($urandom_range(1, 15));
        thr = $urandom_range(1, MAXC - 1);
        for (int k = 0; k < 5; k++) begin
            step(pd(thr));
            if (k < 3) spurious($urandom_range(0, 13));
        end
        #1 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk_ext);
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            thr = $urandom_range(1, MAXC - 1);
            do_start($urandom_range(0, 2));
            for (int k = 0; k < CODE_W; k++) step(pd(thr));
            chk("sarrand", int'(code), thr);
            for (int k = 0; k < 25; k++) step(pd(thr));
            chk("lockrand", int'(locked), 1);
            do_stop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
